// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: owner encodings, default arbitration limits and bus-width helpers
// shared by the dmem_arbiter block, its master interface and its bench.
package dmem_arb_pkg;

    // Owner encoding doubles as the arbiter state: OWN_NONE is the IDLE state.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MAX_BURST    = 8;
    localparam int DEF_STARVE_LIMIT = 16;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one bus master's beat request/response bundle.
// A master holds req and the beat fields until it sees ready.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = DEF_DATA_W
);
    logic                      req;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         wdata;
    logic                      we;
    logic [strb_w(DATA_W)-1:0] wstrb;
    logic                      ready;
    logic [DATA_W-1:0]         rdata;

    modport master (
        output req, addr, wdata, we, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  req, addr, wdata, we, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: up-counter that holds at SAT_VAL; a clear wins over an increment.
module arb_sat_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SAT_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // its inputs from the same pre-edge values, matching the synthesized hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != SAT_VAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: registered two-master ownership arbiter for the single data-RAM port.
// Define ARB_STATS_EN to build the beat/switch statistic counters; otherwise they read 0.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                      clk,
    input  logic                      rst,
    dmem_arbiter_if.slave             m0,
    dmem_arbiter_if.slave             m1,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_we,
    output logic [strb_w(DATA_W)-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [1:0]                owner,
    output logic [15:0]               stat_m0_beats,
    output logic [15:0]               stat_m1_beats,
    output logic [15:0]               stat_switches
);
    localparam int BURST_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [BURST_W-1:0]  BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    owner_e              r_owner;
    owner_e              w_owner_next;
    logic                w_m0_beat;
    logic                w_m1_beat;
    logic                w_burst_last;
    logic                w_starved;
    logic                w_owner_change;
    logic [BURST_W-1:0]  w_burst_cnt;
    logic [STARVE_W-1:0] w_starve_cnt;

    // A beat completes whenever the owner is requesting, so ready is a pure decode.
    assign w_m0_beat      = (r_owner == OWN_M0) && m0.req;
    assign w_m1_beat      = (r_owner == OWN_M1) && m1.req;
    assign w_burst_last   = (w_m0_beat || w_m1_beat) && (w_burst_cnt == BURST_LAST);
    assign w_starved      = (w_starve_cnt == STARVE_MAX);
    assign w_owner_change = (w_owner_next != r_owner);

    assign m0.ready = w_m0_beat;
    assign m1.ready = w_m1_beat;
    assign m0.rdata = mem_rdata;
    assign m1.rdata = mem_rdata;
    assign owner    = r_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_owner_next = r_owner;
        case (r_owner)
            OWN_NONE: begin
                if (m0.req && m1.req) begin
                    w_owner_next = w_starved ? OWN_M1 : OWN_M0;
                end else if (m0.req) begin
                    w_owner_next = OWN_M0;
                end else if (m1.req) begin
                    w_owner_next = OWN_M1;
                end
            end
            OWN_M0: begin
                if (!m0.req) begin
                    w_owner_next = m1.req ? OWN_M1 : OWN_NONE;
                end else if (m1.req && (w_starved || w_burst_last)) begin
                    w_owner_next = OWN_M1;
                end
            end
            OWN_M1: begin
                if (!m1.req) begin
                    w_owner_next = m0.req ? OWN_M0 : OWN_NONE;
                end else if (m0.req && w_burst_last) begin
                    w_owner_next = OWN_M0;
                end
            end
            default: w_owner_next = OWN_NONE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_wstrb = '0;
        case (r_owner)
            OWN_M0: begin
                mem_addr  = m0.addr;
                mem_wdata = m0.wdata;
                mem_we    = m0.we && m0.req;
                mem_wstrb = m0.wstrb;
            end
            OWN_M1: begin
                mem_addr  = m1.addr;
                mem_wdata = m1.wdata;
                mem_we    = m1.we && m1.req;
                mem_wstrb = m1.wstrb;
            end
            default: ;
        endcase
    end

    arb_sat_counter #(
        .WIDTH   (BURST_W),
        .SAT_VAL (BURST_LAST)
    ) u_burst_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_m0_beat || w_m1_beat),
        .i_clr   (w_owner_change),
        .o_count (w_burst_cnt)
    );

    // Master 1 waits only while it requests and does not own, or is about to own, the port.
    arb_sat_counter #(
        .WIDTH   (STARVE_W),
        .SAT_VAL (STARVE_MAX)
    ) u_starve_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (m1.req && (r_owner != OWN_M1)),
        .i_clr   (!m1.req || (w_owner_next == OWN_M1)),
        .o_count (w_starve_cnt)
    );

`ifdef ARB_STATS_EN
    logic w_master_switch;

    assign w_master_switch = ((r_owner == OWN_M0) && (w_owner_next == OWN_M1)) ||
                             ((r_owner == OWN_M1) && (w_owner_next == OWN_M0));

    arb_sat_counter #(.WIDTH(16)) u_stat_m0 (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_m0_beat),
        .i_clr   (1'b0),
        .o_count (stat_m0_beats)
    );

    arb_sat_counter #(.WIDTH(16)) u_stat_m1 (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_m1_beat),
        .i_clr   (1'b0),
        .o_count (stat_m1_beats)
    );

    arb_sat_counter #(.WIDTH(16)) u_stat_sw (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_master_switch),
        .i_clr   (1'b0),
        .o_count (stat_switches)
    );
`else
    assign stat_m0_beats = '0;
    assign stat_m1_beats = '0;
    assign stat_switches = '0;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter for the single data-RAM port. Master 0 is the CPU data interface; master 1 is a secondary bus master, such as a UART program loader or DMA engine. It registers ownership and sequences bursts with fixed CPU priority, a burst cap, and a starvation guard for master 1. It sits between the masters and the RAM/MMIO address decode, and drives one muxed memory request per cycle.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width; strobe width is DATA_W/8
MAX_BURST, 8, max consecutive beats per ownership while the other master is requesting
STARVE_LIMIT, 16, cycles master 1 may wait before forced handover

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
m0_req  in  1  master 0 beat request; held until accepted
m0_addr  in  ADDR_W  master 0 byte address
m0_wdata  in  DATA_W  master 0 write data
m0_we  in  1  master 0 write enable (0 = read)
m0_wstrb  in  DATA_W/8  master 0 byte strobes
m0_ready  out  1  beat accepted this cycle; m0_rdata valid this cycle
m0_rdata  out  DATA_W  read data
m1_req / m1_addr / m1_wdata / m1_we / m1_wstrb / m1_ready / m1_rdata: same as master 0, for master 1
mem_addr  out  ADDR_W  muxed address
mem_wdata  out  DATA_W  muxed write data
mem_we  out  1  muxed write enable
mem_wstrb  out  DATA_W/8  muxed strobes
mem_rdata  in  DATA_W  combinational read data from memory
owner  out  2  current owner: 00 none, 01 M0, 10 M1
stat_m0_beats / stat_m1_beats / stat_switches  out  16 each  statistics (see Optional Feature)

Behaviour:
- Reset (async, immediate):
  - owner=00; burst_cnt=0; starve_cnt=0.
  - All outputs are 0, including mem_we and both ready signals; any in-flight beat is dropped.
- Ownership is registered; the mem_* bus is combinationally muxed from the owning master.
- With owner=00, mem_* outputs are all 0.
- mx_ready = (owner==x) & mx_req. A beat completes on a cycle where mx_req & mx_ready.
- mem_we = owner's we & owner's req, so no write is issued without a request.
- mem_rdata is routed to both mx_rdata outputs; it is only meaningful with mx_ready.
- Arbitration latency: a request seen with owner=00 is granted next cycle. First-beat latency is therefore 1 cycle; subsequent beats are back-to-back.
- FSM states IDLE(00), OWN_M0(01), OWN_M1(10). Next-state is evaluated every cycle, in priority order:
  - IDLE:
    - both request: M0, unless starve_cnt==STARVE_LIMIT, then M1;
    - only one requests: that master;
    - neither requests: stay IDLE.
  - OWN_x, x not requesting: go to the other master if it requests, else IDLE.
  - OWN_M0, m1_req and starve_cnt==STARVE_LIMIT: go to OWN_M1 after the current cycle's beat, regardless of burst_cnt.
  - OWN_x, other master requesting and burst_cnt==MAX_BURST-1 on an accepted beat: switch to the other master.
  - Otherwise stay.
- burst_cnt: cleared on any ownership change; incremented per accepted beat; saturates at MAX_BURST-1.
- starve_cnt:
  - increments each cycle with m1_req=1 and owner!=M1;
  - clears when owner becomes M1 or m1_req=0;
  - saturates at STARVE_LIMIT.
- An ownership switch never splits a beat. The losing master sees ready=0 on the next cycle and keeps req high.
- A master dropping req mid-burst is legal; ownership is released the next cycle.
- Simultaneous same-cycle first requests resolve per the IDLE rule, with no glitching of mem_we.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - stat_m0_beats and stat_m1_beats count accepted beats per master;
  - stat_switches counts ownership changes between M0 and M1, excluding transitions to or from IDLE;
  - all three are 16-bit, saturate at 0xFFFF, and clear on rst.
- Undefined: the ports exist and are tied to 0; no counter logic.

Decomposition:
- Package dmem_arb_pkg:
  - owner encoding constants OWN_NONE=2'b00, OWN_M0=2'b01, OWN_M1=2'b10;
  - default MAX_BURST and STARVE_LIMIT;
  - strobe-width helper constant.
- One sub-module, arb_sat_counter (parameterised width, inc/clr, saturating). It is used for starve_cnt, burst_cnt and the stat counters.

Test Plan:
- Reset and single master:
  - Stimulus: rst pulse mid-write with m0_req=1, m0_we=1.
  - Required: mem_we=0 in the same cycle; owner=00.
  - Stimulus: after release, m0 reads 0x0000_0010.
  - Required: m0_ready on cycle 2; mem_addr=0x10; m0_rdata=mem_rdata.
- Priority:
  - Stimulus: m0_req and m1_req rise together from IDLE.
  - Required: owner=01 next cycle; m1_ready=0.
- Burst cap:
  - Stimulus: m0 streams 20 beats while m1_req is held.
  - Required: m1 is granted after M0's 8th accepted beat (MAX_BURST=8). The M1 grant does not wait for starve_cnt=16.
- Starvation:
  - Stimulus: MAX_BURST=64, STARVE_LIMIT=16; m0 continuous, m1_req held.
  - Required: owner=10 no later than 17 cycles after m1_req rose. No M0 beat is lost; M0 resumes when m1 drops req.
- Byte write routing:
  - Stimulus: m1 writes wstrb=4'b0010, wdata=0xAABBCCDD to 0x0000_0104.
  - Required: mem_wstrb=0010, mem_addr=0x104, mem_we=1 for exactly one cycle.
- Stats (ARB_STATS_EN):
  - Stimulus: 3 M0 beats, switch, 2 M1 beats.
  - Required: stat_m0_beats=3, stat_m1_beats=2, stat_switches=1.
  - Stimulus: same sequence without the macro.
  - Required: all stat outputs are 0.
